// File: rtl/mem_access_sequencer_pkg.sv
// Shared types and constants for the memory access sequencer: FSM states,
// address-select encodings, exception cause codes and vector addresses.
package mem_access_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DATA     = 3'd2,
    ST_EXC_SAVE = 3'd3,
    ST_EXC_READ = 3'd4,
    ST_EXC_LOAD = 3'd5
  } state_e;

  localparam logic [1:0] IORD_PC   = 2'b00;
  localparam logic [1:0] IORD_V254 = 2'b01;
  localparam logic [1:0] IORD_V255 = 2'b10;
  localparam logic [1:0] IORD_ALU  = 2'b11;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_BADOP = 2'b01;
  localparam logic [1:0] CAUSE_OVF   = 2'b10;

  localparam logic [7:0] VEC_ADDR_BADOP = 8'd254;
  localparam logic [7:0] VEC_ADDR_OVF   = 8'd255;

endpackage

// File: rtl/mem_access_sequencer_wait.sv
// Memory latency counter: loads MEM_LAT-1, counts down to zero and flags
// the final cycle of an access.
module mem_wait_counter #(
  parameter int MEM_LAT = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  output logic last_o
);

  localparam logic [3:0] LOAD_VAL = 4'(MEM_LAT - 1);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == 4'd0);

endmodule

// File: rtl/mem_access_sequencer.sv
// Multi-cycle memory access sequencer: arbitrates fetch/data accesses and
// runs the exception entry sequence (save EPC, read vector, load PC).
module mem_access_sequencer
  import mem_access_sequencer_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        fetch_req,
  output logic        fetch_ack,
  input  logic        data_req,
  input  logic        data_we,
  output logic        data_ack,
  input  logic        bad_op,
  input  logic        ovf,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  iord,
  output logic        mem_wr,
  output logic        epc_wr,
  output logic        pc_vec_wr,
  output logic [31:0] pc_vec,
  output logic [1:0]  cause,
  output logic        exc_busy,
  output logic [2:0]  state_dbg
);

  // Handshake: a request is held high until its one-cycle ack; it is only
  // sampled in IDLE, so acks occur exactly once per serviced access.

  state_e      state_q, state_d;
  logic        pend_q, pend_d;
  logic [1:0]  pend_code_q, pend_code_d;
  logic        we_q, we_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] vec_q, vec_d;
  logic        cnt_load;
  logic        cnt_last;
  logic        ev;
  logic [1:0]  ev_code;
  logic        unused_rdata;

  assign unused_rdata = ^mem_rdata[31:8];

  mem_wait_counter #(.MEM_LAT(MEM_LAT)) u_wait (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .load_i (cnt_load),
    .last_o (cnt_last)
  );

  assign ev      = bad_op | ovf;
  assign ev_code = bad_op ? CAUSE_BADOP : (ovf ? CAUSE_OVF : CAUSE_NONE);

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pend_code_d = pend_code_q;
    we_d        = we_q;
    cause_d     = cause_q;
    vec_d       = vec_q;
    cnt_load    = 1'b0;
    iord        = IORD_PC;
    mem_wr      = 1'b0;
    fetch_ack   = 1'b0;
    data_ack    = 1'b0;
    epc_wr      = 1'b0;
    pc_vec_wr   = 1'b0;
    exc_busy    = 1'b0;

    // Events are latched only outside the exception sequence; the first wins.
    if ((state_q == ST_IDLE || state_q == ST_FETCH || state_q == ST_DATA) && ev && !pend_q) begin
      pend_d      = 1'b1;
      pend_code_d = ev_code;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_load = 1'b1;
        if (pend_q || ev) begin
          state_d = ST_EXC_SAVE;
        end else if (data_req) begin
          state_d = ST_DATA;
          we_d    = data_we;
        end else if (fetch_req) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (cnt_last) begin
          fetch_ack = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_DATA: begin
        iord   = IORD_ALU;
        mem_wr = we_q;
        if (cnt_last) begin
          data_ack = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_EXC_SAVE: begin
        epc_wr      = 1'b1;
        exc_busy    = 1'b1;
        cause_d     = pend_code_q;
        pend_d      = 1'b0;
        pend_code_d = CAUSE_NONE;
        cnt_load    = 1'b1;
        state_d     = ST_EXC_READ;
      end
      ST_EXC_READ: begin
        exc_busy = 1'b1;
        iord     = (cause_q == CAUSE_BADOP) ? IORD_V254 : IORD_V255;
        if (cnt_last) begin
          vec_d   = {24'b0, mem_rdata[7:0]};
          state_d = ST_EXC_LOAD;
        end
      end
      ST_EXC_LOAD: begin
        exc_busy  = 1'b1;
        pc_vec_wr = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      pend_q      <= 1'b0;
      pend_code_q <= CAUSE_NONE;
      we_q        <= 1'b0;
      cause_q     <= CAUSE_NONE;
      vec_q       <= 32'd0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_code_q <= pend_code_d;
      we_q        <= we_d;
      cause_q     <= cause_d;
      vec_q       <= vec_d;
    end
  end

  assign pc_vec    = vec_q;
  assign cause     = cause_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer (MEM_LAT=2): per-cycle vector table
// plus hand-written reset sequences and pulse-count totals.
module tb_mem_access_sequencer;

  logic        clock;
  logic        reset_n;
  logic        fetch_req, data_req, data_we, bad_op, ovf;
  logic [31:0] mem_rdata;
  logic        fetch_ack, data_ack, mem_wr, epc_wr, pc_vec_wr, exc_busy;
  logic [1:0]  iord, cause;
  logic [31:0] pc_vec;
  logic [2:0]  state_dbg;

  mem_access_sequencer #(.MEM_LAT(2)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .fetch_req (fetch_req),
    .fetch_ack (fetch_ack),
    .data_req  (data_req),
    .data_we   (data_we),
    .data_ack  (data_ack),
    .bad_op    (bad_op),
    .ovf       (ovf),
    .mem_rdata (mem_rdata),
    .iord      (iord),
    .mem_wr    (mem_wr),
    .epc_wr    (epc_wr),
    .pc_vec_wr (pc_vec_wr),
    .pc_vec    (pc_vec),
    .cause     (cause),
    .exc_busy  (exc_busy),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        fr, dr, we, bo, ov;
    logic [31:0] rd;
    logic        fa, da;
    logic [1:0]  io;
    logic        mw, ew, pw, eb;
    logic [1:0]  ca;
    logic [31:0] pv;
  } vec_t;

  vec_t vtab[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   epc_cnt = 0, pvw_cnt = 0, fack_cnt = 0, dack_cnt = 0;

  always @(negedge clock) begin
    if (epc_wr)    epc_cnt++;
    if (pc_vec_wr) pvw_cnt++;
    if (fetch_ack) fack_cnt++;
    if (data_ack)  dack_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic add(input logic fr, dr, we, bo, ov, input logic [31:0] rd,
                     input logic fa, da, input logic [1:0] io,
                     input logic mw, ew, pw, eb, input logic [1:0] ca, input logic [31:0] pv);
    vec_t v;
    v.fr = fr; v.dr = dr; v.we = we; v.bo = bo; v.ov = ov; v.rd = rd;
    v.fa = fa; v.da = da; v.io = io; v.mw = mw; v.ew = ew; v.pw = pw;
    v.eb = eb; v.ca = ca; v.pv = pv;
    vtab.push_back(v);
  endtask

  // driver: apply one row for one cycle, compare at the falling edge
  task automatic apply_row(input int idx, input vec_t v);
    string t;
    fetch_req = v.fr; data_req = v.dr; data_we = v.we;
    bad_op = v.bo; ovf = v.ov; mem_rdata = v.rd;
    @(negedge clock);
    t = $sformatf("row%0d", idx);
    chk({t, "_fetch_ack"}, fetch_ack, v.fa);
    chk({t, "_data_ack"},  data_ack,  v.da);
    chk({t, "_iord"},      iord,      v.io);
    chk({t, "_mem_wr"},    mem_wr,    v.mw);
    chk({t, "_epc_wr"},    epc_wr,    v.ew);
    chk({t, "_pc_vec_wr"}, pc_vec_wr, v.pw);
    chk({t, "_exc_busy"},  exc_busy,  v.eb);
    chk({t, "_cause"},     cause,     v.ca);
    chk({t, "_pc_vec"},    pc_vec,    v.pv);
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_req = 0; data_req = 0; data_we = 0; bad_op = 0; ovf = 0; mem_rdata = 32'd0;
  endtask

  initial begin : main
    int lat;
    // A: plain fetch
    add(1,0,0,0,0,0,        0,0,2'd0,0,0,0,0,2'd0,32'h0);
    add(1,0,0,0,0,0,        0,0,2'd0,0,0,0,0,2'd0,32'h0);
    add(1,0,0,0,0,0,        1,0,2'd0,0,0,0,0,2'd0,32'h0);
    add(0,0,0,0,0,0,        0,0,2'd0,0,0,0,0,2'd0,32'h0);
    // B: store beats fetch, then fetch
    add(1,1,1,0,0,0,        0,0,2'd0,0,0,0,0,2'd0,32'h0);
    add(1,1,1,0,0,0,        0,0,2'd3,1,0,0,0,2'd0,32'h0);
    add(1,1,1,0,0,0,        0,1,2'd3,1,0,0,0,2'd0,32'h0);
    add(1,0,0,0,0,0,        0,0,2'd0,0,0,0,0,2'd0,32'h0);
    add(1,0,0,0,0,0,        0,0,2'd0,0,0,0,0,2'd0,32'h0);
    add(1,0,0,0,0,0,        1,0,2'd0,0,0,0,0,2'd0,32'h0);
    add(0,0,0,0,0,0,        0,0,2'd0,0,0,0,0,2'd0,32'h0);
    // C: ovf during fetch -> vector 0xA4
    add(1,0,0,0,0,0,        0,0,2'd0,0,0,0,0,2'd0,32'h0);
    add(1,0,0,0,1,0,        0,0,2'd0,0,0,0,0,2'd0,32'h0);
    add(1,0,0,0,0,0,        1,0,2'd0,0,0,0,0,2'd0,32'h0);
    add(0,0,0,0,0,0,        0,0,2'd0,0,0,0,0,2'd0,32'h0);
    add(0,0,0,0,0,0,        0,0,2'd0,0,1,0,1,2'd0,32'h0);
    add(0,0,0,0,0,0,        0,0,2'd2,0,0,0,1,2'd2,32'h0);
    add(0,0,0,0,0,32'hA4,   0,0,2'd2,0,0,0,1,2'd2,32'h0);
    add(0,0,0,0,0,0,        0,0,2'd0,0,0,1,1,2'd2,32'hA4);
    add(0,0,0,0,0,0,        0,0,2'd0,0,0,0,0,2'd2,32'hA4);
    // D: bad_op+ovf in IDLE, ovf during EXC_READ discarded
    add(0,0,0,1,1,0,        0,0,2'd0,0,0,0,0,2'd2,32'hA4);
    add(0,0,0,0,0,0,        0,0,2'd0,0,1,0,1,2'd2,32'hA4);
    add(0,0,0,0,1,0,        0,0,2'd1,0,0,0,1,2'd1,32'hA4);
    add(0,0,0,0,0,32'hFFFF_FF3C, 0,0,2'd1,0,0,0,1,2'd1,32'hA4);
    add(0,0,0,0,0,0,        0,0,2'd0,0,0,1,1,2'd1,32'h3C);
    add(0,0,0,0,0,0,        0,0,2'd0,0,0,0,0,2'd1,32'h3C);
    add(0,0,0,0,0,0,        0,0,2'd0,0,0,0,0,2'd1,32'h3C);
    // E: load with ovf then bad_op (first wins), fetch held through exception
    add(0,1,0,0,0,0,        0,0,2'd0,0,0,0,0,2'd1,32'h3C);
    add(0,1,0,0,1,0,        0,0,2'd3,0,0,0,0,2'd1,32'h3C);
    add(0,1,0,1,0,0,        0,1,2'd3,0,0,0,0,2'd1,32'h3C);
    add(0,0,0,0,0,0,        0,0,2'd0,0,0,0,0,2'd1,32'h3C);
    add(1,0,0,0,0,0,        0,0,2'd0,0,1,0,1,2'd1,32'h3C);
    add(1,0,0,0,0,0,        0,0,2'd2,0,0,0,1,2'd2,32'h3C);
    add(1,0,0,0,0,32'h1234_5680, 0,0,2'd2,0,0,0,1,2'd2,32'h3C);
    add(1,0,0,0,0,0,        0,0,2'd0,0,0,1,1,2'd2,32'h80);
    add(1,0,0,0,0,0,        0,0,2'd0,0,0,0,0,2'd2,32'h80);
    add(1,0,0,0,0,0,        0,0,2'd0,0,0,0,0,2'd2,32'h80);
    add(1,0,0,0,0,0,        1,0,2'd0,0,0,0,0,2'd2,32'h80);
    add(0,0,0,0,0,0,        0,0,2'd0,0,0,0,0,2'd2,32'h80);

    reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_iord", iord, 2'd0);
    chk("rst_busy", exc_busy, 1'b0);
    chk("rst_cause", cause, 2'd0);
    chk("rst_pc_vec", pc_vec, 32'd0);
    chk("rst_state", state_dbg, 3'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    foreach (vtab[i]) apply_row(i, vtab[i]);
    idle_inputs();

    // reset in the middle of EXC_READ
    bad_op = 1'b1;
    @(posedge clock); #1;
    bad_op = 1'b0;
    @(posedge clock); #1;
    chk("pre_rst_busy", exc_busy, 1'b1);
    chk("pre_rst_iord", iord, 2'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("exc_rst_iord", iord, 2'd0);
    chk("exc_rst_busy", exc_busy, 1'b0);
    chk("exc_rst_cause", cause, 2'd0);
    chk("exc_rst_pc_vec", pc_vec, 32'd0);
    chk("exc_rst_pvw", pc_vec_wr, 1'b0);
    chk("exc_rst_state", state_dbg, 3'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // reset in the middle of FETCH: aborted, no ack
    fetch_req = 1'b1;
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    chk("fetch_rst_ack", fetch_ack, 1'b0);
    chk("fetch_rst_state", state_dbg, 3'd0);
    @(negedge clock);
    fetch_req = 1'b0;
    reset_n = 1'b1;
    @(posedge clock); #1;

    // first request after reset is serviced with latency MEM_LAT
    fetch_req = 1'b1;
    lat = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (fetch_ack) begin
        lat = k;
        break;
      end
      @(posedge clock); #1;
    end
    chk("post_rst_fetch_latency", lat, 2);
    @(posedge clock); #1;
    fetch_req = 1'b0;
    repeat (3) @(posedge clock);
    #1;

    chk("total_epc_wr", epc_cnt, 4);
    chk("total_pc_vec_wr", pvw_cnt, 3);
    chk("total_fetch_ack", fack_cnt, 5);
    chk("total_data_ack", dack_cnt, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_access_sequencer.md
MEM_ACCESS_SEQUENCER -- requirements
Module: mem_access_sequencer

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2, memory read/write latency in cycles (legal 1..15).
REQ-002 SHALL have ports: clock  in  1  system clock; reset_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: fetch_req  in  1  instruction fetch request, held until fetch_ack; fetch_ack  out  1  one-cycle pulse, read data valid.
REQ-004 SHALL have ports: data_req  in  1  load/store request, held until data_ack; data_we  in  1  store when 1; data_ack  out  1  one-cycle pulse.
REQ-005 SHALL have ports: bad_op  in  1  invalid-opcode event pulse; ovf  in  1  ALU overflow event pulse.
REQ-006 SHALL have ports: mem_rdata  in  32  memory read data.
REQ-007 SHALL have ports: iord  out  2  memory address select (00 PC, 01 const 254, 10 const 255, 11 ALUOut); mem_wr  out  1  memory write enable.
REQ-008 SHALL have ports: epc_wr  out  1  EPC load pulse; pc_vec_wr  out  1  PC load-from-vector pulse; pc_vec  out  32  vector target; cause  out  2  exception cause register; exc_busy  out  1  exception sequence active.

Function
REQ-009 SHALL implement FSM states IDLE, FETCH, DATA, EXC_SAVE, EXC_READ, EXC_LOAD.
REQ-010 In IDLE, priority SHALL be pending/new exception > data_req > fetch_req; chosen state entered next cycle.
REQ-011 FETCH SHALL last exactly MEM_LAT cycles with iord=00, mem_wr=0; fetch_ack=1 in its last cycle only; next state IDLE.
REQ-012 DATA SHALL last exactly MEM_LAT cycles with iord=11, mem_wr=data_we (sampled at IDLE exit, held); data_ack=1 in last cycle only; next state IDLE.
REQ-013 Request-to-ack latency SHALL be MEM_LAT+1 cycles from the cycle req is seen in IDLE.
REQ-014 bad_op/ovf asserted during FETCH or DATA SHALL set a pending flag and code; current access SHALL complete normally, then IDLE SHALL go to EXC_SAVE.
REQ-015 bad_op and ovf in the same cycle SHALL record cause 01 (bad_op wins); ovf alone records 10; first recorded pending event wins over later ones.
REQ-016 EXC_SAVE SHALL last one cycle: epc_wr=1, cause<=pending code, pending cleared, exc_busy=1.
REQ-017 EXC_READ SHALL last MEM_LAT cycles: iord=01 for cause 01, iord=10 for cause 10, mem_wr=0; in its last cycle vector register <= {24'b0, mem_rdata[7:0]}.
REQ-018 EXC_LOAD SHALL last one cycle: pc_vec_wr=1, pc_vec=vector register; next state IDLE.
REQ-019 exc_busy SHALL be 1 in EXC_SAVE, EXC_READ, EXC_LOAD only.
REQ-020 bad_op/ovf during EXC_SAVE/EXC_READ/EXC_LOAD SHALL be discarded.
REQ-021 fetch_req/data_req SHALL be ignored outside IDLE; no ack without an access.
REQ-022 In IDLE iord SHALL be 00 and mem_wr 0; mem_wr SHALL never be 1 outside DATA.
REQ-023 cause SHALL hold its value until the next EXC_SAVE; pc_vec SHALL hold until next EXC_READ completion.

Reset
REQ-024 reset_n low SHALL immediately force state IDLE, iord=00, mem_wr=0, all acks/pulses 0, exc_busy=0, cause=00, pc_vec=0, pending cleared, wait counter 0.
REQ-025 Reset mid-access or mid-exception SHALL abort without any ack, epc_wr or pc_vec_wr; first request after release is serviced normally.

Structure
REQ-026 Shared package SHALL hold state enum, iord encodings (IORD_PC, IORD_V254, IORD_V255, IORD_ALU), cause codes (CAUSE_NONE 00, CAUSE_BADOP 01, CAUSE_OVF 10) and vector constants 254/255.
REQ-027 Latency counting SHALL be one sub-module mem_wait_counter (load MEM_LAT-1, count down, last-cycle flag).

Verification
REQ-028 MEM_LAT=2, fetch_req at cycle 0 -> iord=00 cycles 1-2, fetch_ack only at cycle 2, IDLE cycle 3.
REQ-029 data_req+data_we=1 and fetch_req together at cycle 0 -> DATA first, mem_wr=1, iord=11 cycles 1-2, data_ack cycle 2; then FETCH, fetch_ack cycle 5.
REQ-030 ovf pulse during FETCH cycle 1 -> fetch_ack cycle 2, epc_wr cycle 4, iord=10 cycles 5-6, mem_rdata=0x0000_00A4 at cycle 6 -> pc_vec_wr cycle 7 with pc_vec=0xA4, cause=10.
REQ-031 bad_op and ovf together in IDLE, mem_rdata=0xFFFF_FF3C -> cause=01, iord=01, pc_vec=0x0000_003C.
REQ-032 reset_n low in EXC_READ -> outputs at reset values same cycle, no pc_vec_wr; later fetch completes normally.
REQ-033 ovf during EXC_READ -> discarded, single epc_wr/pc_vec_wr pair, no second exception.
